morse_key_sequencer: RTL and testbench
======================================

MORSE_KEY_SEQUENCER -- requirements
Module: morse_key_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 5000000, clock50 cycles per timing tick (0.1 s at 50 MHz).
REQ-002 Parameter DEB_CYCLES, default 50000, consecutive stable samples required to accept a key level change.
REQ-003 Parameter DASH_TICKS, default 5, press length in ticks at or above which the symbol is a dash.
REQ-004 Parameter GAP_TICKS, default 7, released length in ticks that ends a letter.
REQ-005 Parameter MAX_SYMS, default 5, maximum symbols per letter.
REQ-006 clock50  in  1  system clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 key_n  in  1  raw Morse key; 0 = pressed; asynchronous, bouncing.
REQ-009 sym_ready  in  1  decoder accepts the symbol this cycle.
REQ-010 sym_valid  out  1  a symbol is presented.
REQ-011 sym_dash  out  1  presented symbol: 1 = dash, 0 = dot; stable while sym_valid=1.
REQ-012 letter_end  out  1  one-cycle pulse; the current letter is complete.
REQ-013 sym_count  out  3  symbols issued in the current letter.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 err  out  1  sticky error flag (overrun or too many symbols); cleared only by reset.

Function
REQ-016 key_n shall pass through a 2-flop synchronizer, then a debouncer; the debounced level shall change only after DEB_CYCLES identical synchronized samples.
REQ-017 A free-running tick counter shall count 0..TICK_DIV-1 and shall assert a one-cycle tick on wrap.
REQ-018 FSM states: IDLE, PRESS, GAP.
REQ-019 IDLE: on a debounced press edge, go to PRESS and clear press_ticks.
REQ-020 PRESS: press_ticks shall increment on each tick and saturate at DASH_TICKS.
REQ-021 PRESS: on a debounced release edge, the block shall issue a symbol with dash = (press_ticks >= DASH_TICKS), clear gap_ticks and go to GAP.
REQ-022 A release with press_ticks = 0 shall be a dot; no press shall be discarded.
REQ-023 GAP: gap_ticks shall increment on each tick.
REQ-024 GAP: a press edge shall return the FSM to PRESS without ending the letter.
REQ-025 GAP: when gap_ticks reaches GAP_TICKS, the FSM shall request letter end and go to IDLE.
REQ-026 Symbol issue: sym_valid and sym_dash shall be registered, with sym_valid rising the cycle after the release edge is detected.
REQ-027 sym_valid shall stay high until a cycle with sym_ready=1, and shall deassert the following cycle.
REQ-028 sym_count shall increment at issue and saturate at 7.
REQ-029 If a new symbol is issued while sym_valid=1 and sym_ready=0, the new symbol shall overwrite the pending one and err shall be set.
REQ-030 If a symbol is issued when sym_count = MAX_SYMS, err shall be set and the symbol shall still be presented.
REQ-031 letter_end shall pulse for one cycle only when no symbol is pending; a pending letter-end request shall wait until the cycle after the last symbol handshake.
REQ-032 sym_count shall clear in the same cycle as letter_end.
REQ-033 Simultaneous tick and key edge: the edge shall take priority; the tick shall not count in the new state.

Reset
REQ-034 While reset=1: FSM = IDLE, all counters = 0, synchronizer and debounced level = released (1), sym_valid=0, sym_dash=0, letter_end=0, sym_count=0, busy=0, err=0.
REQ-035 Reset asserted mid-press or mid-handshake shall drop any pending symbol and any letter-end request without emitting them.
REQ-036 If the key is held at reset release, the block shall start a press only after a fresh debounced press edge.

Structure
REQ-037 A shared package morse_pkg shall hold the FSM state encoding, the default timing constants and the symbol encoding (DOT=0, DASH=1).
REQ-038 The debouncer shall be a separate sub-module, key_debounce (synchronizer, stable counter, level and edge outputs).

Verification (TICK_DIV=4, DEB_CYCLES=2, DASH_TICKS=5, GAP_TICKS=7)
REQ-039 Press 2 ticks, release, sym_ready=1 -> one cycle of sym_valid=1 with sym_dash=0; after 7 ticks of gap, letter_end pulses and sym_count returns to 0.
REQ-040 Press 6 ticks, release -> sym_dash=1; a key_n glitch of 1 cycle mid-press produces no extra symbol.
REQ-041 Hold sym_ready=0 for 10 cycles after issue -> sym_valid and sym_dash stay stable; letter_end is withheld until the cycle after the handshake.
REQ-042 Send dot, dash, dot within one letter, with gaps < 7 ticks -> three handshakes, sym_count = 3, exactly one letter_end.
REQ-043 Send six dots in one letter -> err=1 after the 6th symbol; err stays high after letter_end; reset clears it.
REQ-044 Assert reset mid-press and mid-pending symbol -> all outputs are 0 within the same cycle; no symbol and no letter_end appear after reset release.

Source files
------------

// File: rtl/morse_pkg.sv
// morse_pkg
// Shared definitions for the Morse key sequencer: FSM state encoding,
// default timing constants and the symbol encoding used on sym_dash.
package morse_pkg;

    // Sequencer states: waiting for a letter, key held, key released inside a letter
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } morse_state_t;

    // Default timing: 0.1 s ticks at 50 MHz, 1 ms debounce window
    localparam int DEF_TICK_DIV   = 5000000;
    localparam int DEF_DEB_CYCLES = 50000;
    localparam int DEF_DASH_TICKS = 5;
    localparam int DEF_GAP_TICKS  = 7;
    localparam int DEF_MAX_SYMS   = 5;

    // Symbol encoding carried on sym_dash
    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Synchronizes the raw, bouncing key_n input into the clock50 domain and
// accepts a level change only after DEB_CYCLES identical synchronized samples.
// Ports:
//   clock50      system clock
//   reset        asynchronous active-high reset (level returns to released)
//   key_n        raw key, 0 = pressed
//   level        debounced key level, 0 = pressed
//   press_edge   one-cycle pulse when the debounced level falls to pressed
//   release_edge one-cycle pulse when the debounced level rises to released
module key_debounce
    import morse_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clock50,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press_edge,
    output logic release_edge
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync_0;
    logic          sync_1;
    logic [CW-1:0] stable_cnt;

    // Two-flop synchronizer; resets to the released level so a key held
    // across reset release is seen as a fresh press afterwards
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            sync_0 <= 1'b1;
            sync_1 <= 1'b1;
        end else begin
            sync_0 <= key_n;
            sync_1 <= sync_0;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any
    // sample that agrees restarts the count, so short glitches are ignored.
    // The count reaching DEB_CYCLES-1 means this sample is the DEB_CYCLES-th.
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            level        <= 1'b1;
            stable_cnt   <= '0;
            press_edge   <= 1'b0;
            release_edge <= 1'b0;
        end else begin
            press_edge   <= 1'b0;
            release_edge <= 1'b0;
            if (sync_1 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEB_CYCLES - 1)) begin
                level        <= sync_1;
                stable_cnt   <= '0;
                press_edge   <= ~sync_1;
                release_edge <= sync_1;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/morse_key_sequencer.sv
// morse_key_sequencer
// Turns a bouncing Morse key into a stream of dot/dash symbols with a
// valid/ready handshake, plus a letter_end pulse after a long release.
// Ports:
//   clock50    system clock
//   reset      asynchronous active-high reset
//   key_n      raw key, 0 = pressed
//   sym_ready  downstream decoder accepts the presented symbol
//   sym_valid  a symbol is presented
//   sym_dash   presented symbol, 1 = dash, 0 = dot
//   letter_end one-cycle pulse, current letter complete
//   sym_count  symbols issued in the current letter (saturates at 7)
//   busy       sequencer is not idle
//   err        sticky overrun / too-many-symbols flag
module morse_key_sequencer
    import morse_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int DASH_TICKS = DEF_DASH_TICKS,
    parameter int GAP_TICKS  = DEF_GAP_TICKS,
    parameter int MAX_SYMS   = DEF_MAX_SYMS
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       key_n,
    input  logic       sym_ready,
    output logic       sym_valid,
    output logic       sym_dash,
    output logic       letter_end,
    output logic [2:0] sym_count,
    output logic       busy,
    output logic       err
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int PW = $clog2(DASH_TICKS + 1);
    localparam int GW = $clog2(GAP_TICKS + 1);

    logic          key_level;
    logic          press_edge;
    logic          release_edge;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    morse_state_t  state;
    logic [PW-1:0] press_ticks;
    logic [GW-1:0] gap_ticks;
    logic          le_pending;
    logic          issue;
    logic          le_fire;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_debounce (
        .clock50     (clock50),
        .reset       (reset),
        .key_n       (key_n),
        .level       (key_level),
        .press_edge  (press_edge),
        .release_edge(release_edge)
    );

    // Free-running timebase; tick marks the wrap cycle
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    // A symbol leaves on the release edge of a press. A letter end waits
    // until no symbol is left unaccepted, and never fires alongside a new
    // issue so the count cleared by it cannot swallow a fresh symbol.
    always_comb begin
        issue   = 1'b0;
        le_fire = 1'b0;
        issue   = (state == ST_PRESS) && release_edge;
        le_fire = le_pending && (!sym_valid || sym_ready) && !issue;
    end

    // Sequencer FSM with its counters and all registered outputs. Key edges
    // are checked before tick so a tick coinciding with an edge is dropped.
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            press_ticks <= '0;
            gap_ticks   <= '0;
            le_pending  <= 1'b0;
            sym_valid   <= 1'b0;
            sym_dash    <= SYM_DOT;
            letter_end  <= 1'b0;
            sym_count   <= 3'd0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            letter_end <= 1'b0;

            if (sym_valid && sym_ready) begin
                sym_valid <= 1'b0;
            end

            if (le_fire) begin
                letter_end <= 1'b1;
                le_pending <= 1'b0;
                sym_count  <= 3'd0;
            end

            if (issue) begin
                sym_valid <= 1'b1;
                sym_dash  <= (press_ticks >= PW'(DASH_TICKS)) ? SYM_DASH : SYM_DOT;
                if (sym_valid && !sym_ready) begin
                    err <= 1'b1;
                end
                if (sym_count == 3'(MAX_SYMS)) begin
                    err <= 1'b1;
                end
                if (sym_count != 3'd7) begin
                    sym_count <= sym_count + 3'd1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (press_edge) begin
                        state       <= ST_PRESS;
                        press_ticks <= '0;
                        busy        <= 1'b1;
                    end
                end
                ST_PRESS: begin
                    if (release_edge) begin
                        state     <= ST_GAP;
                        gap_ticks <= '0;
                    end else if (tick && !key_level &&
                                 press_ticks != PW'(DASH_TICKS)) begin
                        press_ticks <= press_ticks + PW'(1);
                    end
                end
                ST_GAP: begin
                    if (press_edge) begin
                        state       <= ST_PRESS;
                        press_ticks <= '0;
                    end else if (tick) begin
                        if (gap_ticks == GW'(GAP_TICKS - 1)) begin
                            state      <= ST_IDLE;
                            gap_ticks  <= '0;
                            le_pending <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            gap_ticks <= gap_ticks + GW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_key_sequencer.sv
// tb_morse_key_sequencer
// Scoreboard bench: stimulus pushes the expected symbol for every key press
// into a queue; a monitor pops and compares on each handshake and watches
// letter_end, stability of a stalled symbol and one-cycle pulses.
module tb_morse_key_sequencer;

    logic       clock50;
    logic       reset;
    logic       key_n;
    logic       sym_ready;
    logic       sym_valid;
    logic       sym_dash;
    logic       letter_end;
    logic [2:0] sym_count;
    logic       busy;
    logic       err;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   hsCount = 0;
    int   leCount = 0;
    int   lastHs = 0;
    int   lastLe = 0;
    logic expQ[$];
    logic prevStall = 1'b0;
    logic prevDash = 1'b0;
    logic prevHs = 1'b0;
    logic prevLe = 1'b0;

    morse_key_sequencer #(
        .TICK_DIV  (4),
        .DEB_CYCLES(2),
        .DASH_TICKS(5),
        .GAP_TICKS (7),
        .MAX_SYMS  (5)
    ) dut (
        .clock50   (clock50),
        .reset     (reset),
        .key_n     (key_n),
        .sym_ready (sym_ready),
        .sym_valid (sym_valid),
        .sym_dash  (sym_dash),
        .letter_end(letter_end),
        .sym_count (sym_count),
        .busy      (busy),
        .err       (err)
    );

    initial clock50 = 1'b0;
    always #5 clock50 = ~clock50;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    always @(negedge clock50) begin
        cyc++;
        if (reset) begin
            prevStall = 1'b0;
            prevHs    = 1'b0;
            prevLe    = 1'b0;
        end else begin
            if (sym_valid && prevStall)
                checkOutput("sym_dash stable while stalled", int'(sym_dash), int'(prevDash));
            if (prevHs)
                checkOutput("sym_valid drops after handshake", int'(sym_valid), 0);
            if (sym_valid && sym_ready) begin
                hsCount++;
                lastHs = cyc;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected symbol (queue empty)", 1, 0);
                end else begin
                    checkOutput("symbol dash", int'(sym_dash), int'(expQ.pop_front()));
                end
            end
            if (letter_end) begin
                leCount++;
                lastLe = cyc;
                checkOutput("sym_count at letter_end", int'(sym_count), 0);
                checkOutput("letter_end while symbol stalled", int'(prevStall), 0);
                checkOutput("letter_end one cycle", int'(prevLe), 0);
            end
            prevStall = sym_valid && !sym_ready;
            prevDash  = sym_dash;
            prevHs    = sym_valid && sym_ready;
            prevLe    = letter_end;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock50);
        #1;
    endtask

    // Press the key for holdCycles, release, and record the expected symbol
    task automatic applyStimulus(input int holdCycles, input logic expDash, input int glitchAt);
        key_n = 1'b0;
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clock50);
            #1;
            key_n = (i == glitchAt) ? 1'b1 : 1'b0;
        end
        key_n = 1'b1;
        expQ.push_back(expDash);
    endtask

    task automatic waitLetterEnd(input int startCount, input int budget, input string name);
        int n;
        n = 0;
        while (leCount == startCount && n < budget) begin
            @(posedge clock50);
            n++;
        end
        waitCycles(3);
        checkOutput(name, leCount - startCount, 1);
    endtask

    task automatic waitValid(input int budget, input string name);
        int n;
        n = 0;
        while (!sym_valid && n < budget) begin
            @(posedge clock50);
            #1;
            n++;
        end
        checkOutput(name, int'(sym_valid), 1);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        expQ.delete();
        waitCycles(3);
        reset = 1'b0;
    endtask

    initial begin
        int hs0;
        int le0;
        reset     = 1'b1;
        key_n     = 1'b1;
        sym_ready = 1'b1;
        waitCycles(3);
        checkOutput("reset sym_valid", int'(sym_valid), 0);
        checkOutput("reset sym_dash", int'(sym_dash), 0);
        checkOutput("reset letter_end", int'(letter_end), 0);
        checkOutput("reset sym_count", int'(sym_count), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset err", int'(err), 0);
        reset = 1'b0;
        waitCycles(5);

        $display("[TB] single dot with immediate accept");
        hs0 = hsCount; le0 = leCount;
        applyStimulus(8, 1'b0, -1);
        waitCycles(10);
        checkOutput("dot sym_count", int'(sym_count), 1);
        checkOutput("dot busy in gap", int'(busy), 1);
        waitLetterEnd(le0, 80, "dot letter_end count");
        checkOutput("dot handshakes", hsCount - hs0, 1);
        checkOutput("dot sym_count after letter", int'(sym_count), 0);
        checkOutput("dot busy after letter", int'(busy), 0);

        $display("[TB] dash with a one-cycle glitch");
        hs0 = hsCount; le0 = leCount;
        applyStimulus(30, 1'b1, 15);
        waitLetterEnd(le0, 80, "dash letter_end count");
        checkOutput("dash handshakes", hsCount - hs0, 1);

        $display("[TB] dot dash dot in one letter");
        hs0 = hsCount; le0 = leCount;
        applyStimulus(8, 1'b0, -1);
        waitCycles(12);
        applyStimulus(30, 1'b1, -1);
        waitCycles(12);
        applyStimulus(8, 1'b0, -1);
        waitCycles(10);
        checkOutput("three symbols sym_count", int'(sym_count), 3);
        checkOutput("no letter_end inside letter", leCount - le0, 0);
        waitLetterEnd(le0, 80, "three symbols letter_end count");
        checkOutput("three symbols handshakes", hsCount - hs0, 3);

        $display("[TB] stalled symbol holds letter_end back");
        hs0 = hsCount; le0 = leCount;
        sym_ready = 1'b0;
        applyStimulus(30, 1'b1, -1);
        waitValid(20, "stall sym_valid rises");
        waitCycles(10);
        checkOutput("stall sym_valid after 10", int'(sym_valid), 1);
        checkOutput("stall sym_dash after 10", int'(sym_dash), 1);
        waitCycles(30);
        checkOutput("stall sym_valid held", int'(sym_valid), 1);
        checkOutput("stall letter_end withheld", leCount - le0, 0);
        checkOutput("stall no error", int'(err), 0);
        sym_ready = 1'b1;
        waitLetterEnd(le0, 20, "stall letter_end count");
        checkOutput("stall handshakes", hsCount - hs0, 1);
        checkOutput("letter_end cycle after handshake", lastLe - lastHs, 1);

        $display("[TB] six dots overflow the letter");
        hs0 = hsCount; le0 = leCount;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(8, 1'b0, -1);
            waitCycles(10);
            if (k == 4) checkOutput("err after five symbols", int'(err), 0);
            if (k < 5) waitCycles(2);
        end
        checkOutput("err after sixth symbol", int'(err), 1);
        checkOutput("six symbols sym_count", int'(sym_count), 6);
        waitLetterEnd(le0, 80, "six dots letter_end count");
        checkOutput("six dots handshakes", hsCount - hs0, 6);
        checkOutput("err sticky after letter_end", int'(err), 1);
        pulseReset();
        checkOutput("err cleared by reset", int'(err), 0);
        waitCycles(5);

        $display("[TB] reset mid-press");
        hs0 = hsCount; le0 = leCount;
        key_n = 1'b0;
        waitCycles(12);
        checkOutput("mid-press busy", int'(busy), 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("mid-press reset busy", int'(busy), 0);
        checkOutput("mid-press reset sym_valid", int'(sym_valid), 0);
        key_n = 1'b1;
        pulseReset();
        waitCycles(60);
        checkOutput("mid-press no symbol after reset", hsCount - hs0, 0);
        checkOutput("mid-press no letter_end after reset", leCount - le0, 0);

        $display("[TB] reset with a pending symbol");
        hs0 = hsCount; le0 = leCount;
        sym_ready = 1'b0;
        applyStimulus(30, 1'b1, -1);
        waitValid(20, "pending sym_valid rises");
        waitCycles(3);
        #1 reset = 1'b1;
        #1;
        checkOutput("pending reset sym_valid", int'(sym_valid), 0);
        checkOutput("pending reset sym_dash", int'(sym_dash), 0);
        checkOutput("pending reset sym_count", int'(sym_count), 0);
        checkOutput("pending reset letter_end", int'(letter_end), 0);
        pulseReset();
        sym_ready = 1'b1;
        waitCycles(60);
        checkOutput("pending no symbol after reset", hsCount - hs0, 0);
        checkOutput("pending no letter_end after reset", leCount - le0, 0);
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
